// File: rtl/droute_pack_128to1536.sv
// ----------------------------------------------------------------------------
// droute_pack_128to1536
//
// Width up-converter placed directly behind data_route's 128-bit output ports.
// Packs RATIO consecutive IN_WIDTH-bit AXI-Stream beats into one wide word for
// the systolic array's operand input.  A beat carrying s_tlast closes the
// current group early; lanes that were never written are driven as zero and
// m_tkeep marks the lanes that hold real data.  Lanes always fill from lane 0
// upward, so m_tkeep is always a contiguous low-order mask.
//
// The output is a single register stage.  With m_tready held high the block
// accepts one input beat per cycle and never inserts a bubble, because a new
// word can be loaded on the same edge the previous one is handed off.
// ----------------------------------------------------------------------------
module droute_pack_128to1536 #(
  parameter int IN_WIDTH  = 128,
  parameter int RATIO     = 12,
  parameter int CNT_WIDTH = 16,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO
) (
  input  logic                 clk,
  input  logic                 rst_n,

  // Narrow input stream
  input  logic [IN_WIDTH-1:0]  s_tdata,
  input  logic                 s_tvalid,
  input  logic                 s_tlast,
  output logic                 s_tready,

  // Wide output stream
  output logic [OUT_WIDTH-1:0] m_tdata,
  output logic [RATIO-1:0]     m_tkeep,
  output logic                 m_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,

  // Status
  output logic [CNT_WIDTH-1:0] word_count,
  output logic                 partial
);

  // Lane index width; a RATIO of 1 still needs one bit to keep the logic legal.
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0]                idx;        // next lane to be written
  logic [RATIO-1:0][IN_WIDTH-1:0]  acc_data;   // lanes collected so far
  logic [RATIO-1:0]                acc_keep;   // which lanes of acc_data are real

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic accept;    // an input beat is consumed at this edge
  logic complete;  // the consumed beat closes its group
  logic out_fire;  // the held output word is consumed at this edge

  // The output register can take a new word when it is empty or being drained
  // this cycle; nothing is accepted while reset is applied.
  assign s_tready = rst_n & (~m_tvalid | m_tready);
  assign accept   = s_tvalid & s_tready;
  assign complete = accept & ((idx == LAST_IDX) | s_tlast);
  assign out_fire = m_tvalid & m_tready;

  assign partial  = (idx != '0);

  // --------------------------------------------------------------------------
  // Merge the current beat into the accumulator image.  This single view feeds
  // both the accumulator update and the output register load, so the word sent
  // downstream is exactly what the accumulator would have held.
  // --------------------------------------------------------------------------
  logic [RATIO-1:0][IN_WIDTH-1:0]  merged_data;
  logic [RATIO-1:0]                merged_keep;

  // Build the accumulator contents as they look with this cycle's beat applied.
  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path can
    // leave it unassigned; otherwise synthesis would infer a latch.
    merged_data = '0;
    merged_keep = acc_keep;
    for (int i = 0; i < RATIO; i++) begin
      if (accept && (idx == IDX_W'(i))) begin
        merged_data[i] = s_tdata;
        merged_keep[i] = 1'b1;
      end else if (acc_keep[i]) begin
        // Lanes never written stay at the zero default, so short groups are
        // padded with zeros regardless of what the accumulator last held.
        merged_data[i] = acc_data[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Accumulator and lane index
  // --------------------------------------------------------------------------

  // Collect beats lane by lane; empty the accumulator when its group is sent.
  always_ff @(posedge clk) begin
    // NOTE: the accumulator is a wide register bank, but it is cleared on
    // reset on purpose: a reset mid-group must discard the partial data so no
    // stale lanes can leak into the next word.
    if (!rst_n) begin
      idx      <= '0;
      acc_data <= '0;
      acc_keep <= '0;
    end else if (complete) begin
      idx      <= '0;
      acc_data <= '0;
      acc_keep <= '0;
    end else if (accept) begin
      // NOTE: state registers use non-blocking assignments so every flop in
      // this block samples the pre-edge values, matching real hardware.
      idx      <= idx + 1'b1;
      acc_data <= merged_data;
      acc_keep <= merged_keep;
    end
  end

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------

  // Load a finished group; otherwise hold the word until it is handed off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
      m_tvalid <= 1'b0;
    end else if (complete) begin
      // A completing beat can only be accepted when the register is empty or
      // draining, so overwriting here never loses an unconsumed word.
      m_tdata  <= merged_data;
      m_tkeep  <= merged_keep;
      m_tlast  <= s_tlast;
      m_tvalid <= 1'b1;
    end else if (out_fire) begin
      m_tvalid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Output word counter
  // --------------------------------------------------------------------------

  // Count output handshakes; the counter wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_count <= '0;
    end else if (out_fire) begin
      word_count <= word_count + 1'b1;
    end
  end

endmodule
